// File: rtl/seq_pkg.sv
// -----------------------------------------------------------------------------
// seq_pkg
// Shared definitions for the serial sequence generator and its companion
// sequence detector benches: FSM state encodings, the default maximum pattern
// length, and small helpers used when sizing and qualifying requests.
// No ports (package).
// -----------------------------------------------------------------------------
package seq_pkg;

    // FSM state encoding, fixed so that detector benches can decode it.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } seq_state_t;

    // Default maximum pattern length in bits.
    localparam int SEQ_MAX_LEN = 8;

    // Width of a bit index able to address every bit of a max_len pattern.
    // A one-bit pattern still gets a one-bit counter so the vector is legal.
    function automatic int idx_width(input int max_len);
        if (max_len > 1) begin
            return $clog2(max_len);
        end else begin
            return 1;
        end
    endfunction

    // A requested length is usable only when it lies in 1..max_len.
    function automatic logic len_in_range(input logic [3:0] len, input int max_len);
        return (len != 4'd0) && (int'(len) <= max_len);
    endfunction

endpackage : seq_pkg

// File: rtl/seq_down_counter.sv
// -----------------------------------------------------------------------------
// seq_down_counter
// Loadable down counter with a zero flag. A load takes priority over a
// decrement; a decrement request while already at zero holds the value, so the
// counter never wraps below zero.
//
// Ports:
//   clk       in   clock, state updates on posedge
//   reset     in   asynchronous active-high reset, clears the count
//   load      in   load load_val on the next edge
//   load_val  in   [W-1:0] value to load
//   dec       in   decrement on the next edge (ignored at zero)
//   count     out  [W-1:0] current registered count
//   zero      out  high while count is zero
// -----------------------------------------------------------------------------
module seq_down_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         zero
);

    logic [W-1:0] count_r;
    logic [W-1:0] count_next_s;

    // Next-count selection: load, saturating decrement, or hold.
    always_comb begin
        count_next_s = count_r;
        if (load) begin
            count_next_s = load_val;
        end else if (dec && (count_r != {W{1'b0}})) begin
            count_next_s = count_r - W'(1);
        end else begin
            count_next_s = count_r;
        end
    end

    // Count register with asynchronous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_r <= {W{1'b0}};
        end else begin
            count_r <= count_next_s;
        end
    end

    assign count = count_r;
    assign zero  = (count_r == {W{1'b0}});

endmodule : seq_down_counter

// File: rtl/sequence_generator.sv
// -----------------------------------------------------------------------------
// sequence_generator
// Serialises a right-justified bit pattern MSB-first (from bit len-1), repeated
// back-to-back max(repeat_n,1) times, then pulses done for one cycle. Built as
// a three-state Moore FSM (IDLE, SHIFT, DONE); every output is decoded from
// registered state only. An abort in SHIFT returns to IDLE without a done pulse.
//
// Ports:
//   clk       in   clock, all state updates on posedge
//   reset     in   asynchronous active-high reset
//   start     in   begin transmission (sampled only in IDLE)
//   pattern   in   [MAX_LEN-1:0] right-justified pattern
//   len       in   [3:0] pattern length, legal 1..MAX_LEN
//   repeat_n  in   [REP_W-1:0] repetition count, 0 behaves as 1
//                  (named repeat_n because "repeat" is a reserved word)
//   abort     in   cancel an in-progress transmission
//   x         out  serial data bit (0 when not valid)
//   valid     out  x carries a pattern bit this cycle
//   busy      out  high in SHIFT and DONE
//   done      out  one-cycle pulse on normal completion
// -----------------------------------------------------------------------------
module sequence_generator
    import seq_pkg::*;
#(
    parameter int MAX_LEN = SEQ_MAX_LEN,
    parameter int REP_W   = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [MAX_LEN-1:0] pattern,
    input  logic [3:0]         len,
    input  logic [REP_W-1:0]   repeat_n,
    input  logic               abort,
    output logic               x,
    output logic               valid,
    output logic               busy,
    output logic               done
);

    localparam int IDX_W = idx_width(MAX_LEN);

    seq_state_t         state_r;
    seq_state_t         state_next_s;
    logic [MAX_LEN-1:0] pattern_r;
    logic [3:0]         len_r;

    logic               capture_s;
    logic               len_ok_s;
    logic               bit_load_s;
    logic               bit_dec_s;
    logic [IDX_W-1:0]   bit_load_val_s;
    logic [IDX_W-1:0]   bit_idx_s;
    logic               bit_zero_s;
    logic               rep_load_s;
    logic               rep_dec_s;
    logic [REP_W-1:0]   rep_load_val_s;
    logic [REP_W-1:0]   rep_count_unused_s;
    logic               rep_zero_s;

    assign len_ok_s = len_in_range(len, MAX_LEN);

    // The repeat counter holds repetitions still to come after the current
    // one, so it is loaded with max(repeat_n,1)-1.
    assign rep_load_val_s = (repeat_n == {REP_W{1'b0}}) ? {REP_W{1'b0}}
                                                        : (repeat_n - REP_W'(1));

    // Reloads mid-stream must use the captured length, never the live input.
    assign bit_load_val_s = capture_s ? IDX_W'(len - 4'd1) : IDX_W'(len_r - 4'd1);

    // Next-state and counter-control decode.
    always_comb begin
        state_next_s = state_r;
        capture_s    = 1'b0;
        bit_load_s   = 1'b0;
        bit_dec_s    = 1'b0;
        rep_load_s   = 1'b0;
        rep_dec_s    = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (start && len_ok_s) begin
                    capture_s    = 1'b1;
                    bit_load_s   = 1'b1;
                    rep_load_s   = 1'b1;
                    state_next_s = S_SHIFT;
                end else begin
                    state_next_s = S_IDLE;
                end
            end
            S_SHIFT: begin
                // Abort wins over completion on the same edge.
                if (abort) begin
                    state_next_s = S_IDLE;
                end else if (bit_zero_s) begin
                    if (rep_zero_s) begin
                        state_next_s = S_DONE;
                    end else begin
                        // Seamless reload: next cycle carries bit len-1 again.
                        bit_load_s   = 1'b1;
                        rep_dec_s    = 1'b1;
                        state_next_s = S_SHIFT;
                    end
                end else begin
                    bit_dec_s    = 1'b1;
                    state_next_s = S_SHIFT;
                end
            end
            S_DONE: begin
                state_next_s = S_IDLE;
            end
            default: begin
                state_next_s = S_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Captured pattern and length; frozen for the whole transmission.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pattern_r <= {MAX_LEN{1'b0}};
            len_r     <= 4'd0;
        end else if (capture_s) begin
            pattern_r <= pattern;
            len_r     <= len;
        end else begin
            pattern_r <= pattern_r;
            len_r     <= len_r;
        end
    end

    seq_down_counter #(
        .W (IDX_W)
    ) u_bit_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (bit_load_s),
        .load_val (bit_load_val_s),
        .dec      (bit_dec_s),
        .count    (bit_idx_s),
        .zero     (bit_zero_s)
    );

    seq_down_counter #(
        .W (REP_W)
    ) u_rep_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (rep_load_s),
        .load_val (rep_load_val_s),
        .dec      (rep_dec_s),
        .count    (rep_count_unused_s),
        .zero     (rep_zero_s)
    );

    // Moore output decode from registered state, index and pattern.
    assign x     = (state_r == S_SHIFT) ? pattern_r[bit_idx_s] : 1'b0;
    assign valid = (state_r == S_SHIFT);
    assign busy  = (state_r == S_SHIFT) || (state_r == S_DONE);
    assign done  = (state_r == S_DONE);

endmodule : sequence_generator

// File: tb/tb_sequence_generator.sv
// -----------------------------------------------------------------------------
// tb_sequence_generator
// Directed bench for sequence_generator with hand-computed expected streams.
// Inputs change 1 time unit after each rising edge; outputs are sampled there.
// -----------------------------------------------------------------------------
module tb_sequence_generator;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [7:0] pattern = 8'd0;
    logic [3:0] len = 4'd0;
    logic [3:0] rep = 4'd0;
    logic       abort = 1'b0;
    logic       x;
    logic       valid;
    logic       busy;
    logic       done;

    int total = 0;
    int bad = 0;

    sequence_generator #(
        .MAX_LEN (8),
        .REP_W   (4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .pattern  (pattern),
        .len      (len),
        .repeat_n (rep),
        .abort    (abort),
        .x        (x),
        .valid    (valid),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic ex, input logic ev,
                           input logic eb, input logic ed);
        chk({tag, ".x"}, {31'd0, x}, {31'd0, ex});
        chk({tag, ".valid"}, {31'd0, valid}, {31'd0, ev});
        chk({tag, ".busy"}, {31'd0, busy}, {31'd0, eb});
        chk({tag, ".done"}, {31'd0, done}, {31'd0, ed});
    endtask

    task automatic launch(input logic [7:0] p, input logic [3:0] l, input logic [3:0] r);
        pattern = p;
        len     = l;
        rep     = r;
        start   = 1'b1;
        step();
        start   = 1'b0;
    endtask

    // Called on the first valid cycle; checks n bits, the done pulse, then IDLE.
    task automatic expect_stream(input string tag, input logic [63:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            chk_out($sformatf("%s.b%0d", tag, i), bits[n-1-i], 1'b1, 1'b1, 1'b0);
            step();
        end
        chk_out({tag, ".done"}, 1'b0, 1'b0, 1'b1, 1'b1);
        step();
        chk_out({tag, ".idle"}, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state, before and after a clock edge while held.
        #2;
        chk_out("reset0", 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        chk_out("reset1", 1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;

        // First start after release; 6-bit alternating pattern.
        launch(8'b0010_1010, 4'd6, 4'd1);
        expect_stream("p101010", 64'b101010, 6);

        // Three back-to-back repetitions with no gap.
        launch(8'b0000_0110, 4'd4, 4'd3);
        expect_stream("p0110x3", 64'b0110_0110_0110, 12);

        // repeat 0 behaves as a single repetition.
        launch(8'b0000_0101, 4'd3, 4'd0);
        expect_stream("rep0", 64'b101, 3);

        // Maximum length.
        launch(8'b1000_0001, 4'd8, 4'd1);
        expect_stream("len8", 64'b1000_0001, 8);

        // Minimum length, with abort held in IDLE (must not block start).
        abort = 1'b1;
        launch(8'b0000_0001, 4'd1, 4'd1);
        abort = 1'b0;
        expect_stream("len1", 64'b1, 1);

        // Illegal lengths are ignored.
        launch(8'hFF, 4'd0, 4'd1);
        for (int i = 0; i < 3; i++) begin
            chk_out($sformatf("len0.c%0d", i), 1'b0, 1'b0, 1'b0, 1'b0);
            step();
        end
        launch(8'hFF, 4'd9, 4'd1);
        for (int i = 0; i < 3; i++) begin
            chk_out($sformatf("len9.c%0d", i), 1'b0, 1'b0, 1'b0, 1'b0);
            step();
        end

        // Inputs changed and start re-asserted mid-stream have no effect.
        launch(8'b0001_1001, 4'd5, 4'd2);
        for (int i = 0; i < 10; i++) begin
            logic [9:0] exp_bits;
            exp_bits = 10'b11001_11001;
            chk_out($sformatf("hold.b%0d", i), exp_bits[9-i], 1'b1, 1'b1, 1'b0);
            if (i == 0) begin
                start   = 1'b1;
                pattern = 8'hFF;
                len     = 4'd2;
                rep     = 4'd7;
            end
            if (i == 5) begin
                start = 1'b0;
            end
            step();
        end
        chk_out("hold.done", 1'b0, 1'b0, 1'b1, 1'b1);
        step();
        chk_out("hold.idle", 1'b0, 1'b0, 1'b0, 1'b0);

        // Abort on the third valid cycle: no done pulse follows.
        launch(8'b0010_1010, 4'd6, 4'd1);
        for (int i = 0; i < 3; i++) begin
            logic [5:0] exp_bits;
            exp_bits = 6'b101010;
            chk_out($sformatf("abort.b%0d", i), exp_bits[5-i], 1'b1, 1'b1, 1'b0);
            if (i == 2) begin
                abort = 1'b1;
            end
            step();
        end
        chk_out("abort.next", 1'b0, 1'b0, 1'b0, 1'b0);
        abort = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_out($sformatf("abort.after%0d", i), 1'b0, 1'b0, 1'b0, 1'b0);
        end

        // Asynchronous reset mid-stream, then a clean restart from bit len-1.
        launch(8'b0011_0011, 4'd6, 4'd2);
        for (int i = 0; i < 2; i++) begin
            chk_out($sformatf("rst.b%0d", i), 1'b1, 1'b1, 1'b1, 1'b0);
            step();
        end
        #2;
        reset = 1'b1;
        #1;
        chk_out("rst.async", 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        reset = 1'b0;
        step();
        chk_out("rst.idle0", 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        chk_out("rst.idle1", 1'b0, 1'b0, 1'b0, 1'b0);
        launch(8'b0011_0011, 4'd6, 4'd1);
        expect_stream("after_rst", 64'b110011, 6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_sequence_generator

// File: doc/sequence_generator.md
SEQUENCE_GENERATOR -- requirements
Module: sequence_generator

Interface
REQ-001 Parameter MAX_LEN, default 8, SHALL set the maximum pattern length in bits.
REQ-002 Parameter REP_W, default 4, SHALL set the width of the repeat-count input.
REQ-003 clk  input  1  SHALL be the single clock; all state SHALL update on posedge clk.
REQ-004 reset  input  1  SHALL be the asynchronous, active-high reset.
REQ-005 start  input  1  SHALL be the request to begin transmission, sampled only in IDLE.
REQ-006 pattern  input  MAX_LEN  SHALL be the bit pattern, right-justified, transmitted MSB-first from bit len-1.
REQ-007 len  input  4  SHALL be the pattern length; the legal range is 1..MAX_LEN.
REQ-008 repeat  input  REP_W  SHALL be the number of back-to-back pattern repetitions; 0 SHALL be treated as 1.
REQ-009 abort  input  1  SHALL cancel an in-progress transmission.
REQ-010 x  output  1  SHALL be the serial data bit, suitable for direct connection to sequence_detector input x.
REQ-011 valid  output  1  SHALL be high exactly on cycles where x carries a pattern bit.
REQ-012 busy  output  1  SHALL be high in SHIFT and DONE.
REQ-013 done  output  1  SHALL be a one-cycle pulse on normal completion.

Function
REQ-014 The FSM SHALL have exactly the states IDLE, SHIFT and DONE; all outputs SHALL be decoded from registered state (Moore).
- IDLE: x=0, valid=0, busy=0, done=0.
REQ-015 In IDLE, start=1 with len in 1..MAX_LEN SHALL capture pattern, len and repeat into internal registers and enter SHIFT on that edge.
REQ-016 In IDLE, start=1 with len=0 or len>MAX_LEN SHALL be ignored and the FSM SHALL remain in IDLE.
REQ-017 In SHIFT, x SHALL equal captured pattern[bit_idx] and valid SHALL be 1.
- bit_idx starts at len-1 and decrements each cycle.
REQ-018 When bit_idx reaches 0 and repetitions remain, bit_idx SHALL reload to len-1 on the next edge with no gap cycle.
REQ-019 After the last bit of the last repetition, the FSM SHALL enter DONE for exactly one cycle (done=1, valid=0, x=0), then return to IDLE.
REQ-020 Total valid cycles SHALL be len*max(repeat,1). The first bit SHALL appear on the cycle immediately after the edge that samples start.
REQ-021 start SHALL be ignored in SHIFT and DONE, and input changes during SHIFT SHALL NOT affect the captured values.
REQ-022 abort=1 in SHIFT SHALL return the FSM to IDLE on the next edge without a done pulse.
REQ-023 abort SHALL take priority over normal completion on the same edge.
REQ-024 abort SHALL have no effect in IDLE or DONE.
REQ-025 The bit counter SHALL be ceil(log2(MAX_LEN)) bits and the repeat counter REP_W bits; neither counter SHALL wrap below 0.

Reset
REQ-026 reset=1 SHALL immediately force IDLE and clear all captured registers and counters, independent of clk.
- All outputs become 0 (x=0, valid=0, busy=0, done=0).
REQ-027 Reset asserted mid-SHIFT SHALL abandon the transmission with no done pulse.
REQ-028 The first start after reset release SHALL be honoured on the first posedge.

Structure
REQ-029 The state encodings (S_IDLE=0, S_SHIFT=1, S_DONE=2) and the MAX_LEN default SHALL reside in shared package seq_pkg, for reuse by sequence_detector benches.
REQ-030 A single sub-module, seq_down_counter (loadable, decrementing, with zero flag), SHALL be instantiated twice: once for bit_idx and once for the repeat count.

Verification
REQ-031 pattern=6'b101010, len=6, repeat=1, start pulse -> x=1,0,1,0,1,0 on six valid cycles, then done=1 for one cycle; a connected sequence_detector SHALL assert z on the final bit.
REQ-032 pattern=4'b0110, len=4, repeat=3 -> 12 contiguous valid cycles with x=0110 0110 0110, then a single done pulse.
REQ-033 len=0 with start=1, and separately len=9 with start=1 -> busy remains 0 and valid never rises.
REQ-034 start re-asserted and pattern changed during SHIFT -> the original sequence completes unchanged.
REQ-035 abort=1 on the 3rd valid cycle of len=6 -> valid=0 and busy=0 on the next cycle, and done never pulses.
REQ-036 reset pulsed asynchronously mid-SHIFT -> all outputs 0 immediately; the next start transmits correctly from bit len-1.
